// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix storage / display path.
package matrix_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_META,
        ST_REQ,
        ST_WAIT_DATA,
        ST_CONV,
        ST_EMIT,
        ST_SEP,
        ST_CR,
        ST_LF,
        ST_DONE,
        ST_ABORT
    } fmt_state_e;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    localparam int MAX_MATRICES = 10;
    localparam int MAX_DIM      = 5;

endpackage

// File: rtl/int8_to_ascii.sv
// Signed 8-bit to decimal ASCII, leading zeros suppressed.
module int8_to_ascii
    import matrix_pkg::*;
(
    input  logic [7:0]      value,
    output logic [3:0][7:0] char_buf,
    output logic [2:0]      char_len
);

    logic       neg;
    logic [7:0] mag;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;

    // -128 negates to 8'h80, which reads correctly as unsigned 128
    assign neg = value[7];
    assign mag = neg ? (~value + 8'd1) : value;
    assign hun = 4'(mag / 8'd100);
    assign ten = 4'((mag / 8'd10) % 8'd10);
    assign one = 4'(mag % 8'd10);

    always_comb begin
        char_buf = '0;
        char_len = 3'd0;
        if (neg) begin
            char_buf[char_len[1:0]] = CHAR_MINUS;
            char_len = char_len + 3'd1;
        end
        if (hun != 4'd0) begin
            char_buf[char_len[1:0]] = CHAR_ZERO + {4'd0, hun};
            char_len = char_len + 3'd1;
        end
        if (hun != 4'd0 || ten != 4'd0) begin
            char_buf[char_len[1:0]] = CHAR_ZERO + {4'd0, ten};
            char_len = char_len + 3'd1;
        end
        char_buf[char_len[1:0]] = CHAR_ZERO + {4'd0, one};
        char_len = char_len + 3'd1;
    end

endmodule

// File: rtl/matrix_display_formatter.sv
// Reads a stored matrix element by element and prints it as ASCII rows.
module matrix_display_formatter
    import matrix_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter int         MAX_DIM        = 5,
    parameter logic [7:0] SEP_CHAR       = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fmt_start,
    input  logic [3:0] fmt_id,
    input  logic [2:0] fmt_m,
    input  logic [2:0] fmt_n,
    output logic       fmt_busy,
    output logic       fmt_done,
    output logic       fmt_err,
    output logic       start_disp,
    output logic [3:0] disp_id,
    output logic       read_en,
    input  logic       meta_info_valid,
    input  logic       error_flag,
    input  logic [7:0] st_data,
    input  logic       matrix_data_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    DIM_HI   = 3'(MAX_DIM);
    localparam logic [3:0]    ID_HI    = 4'(MAX_MATRICES - 1);

    fmt_state_e      state_q;
    fmt_state_e      state_d;
    logic [3:0]      id_q;
    logic [2:0]      m_q;
    logic [2:0]      n_q;
    logic [2:0]      row_q;
    logic [2:0]      col_q;
    logic [TW-1:0]   timer_q;
    logic [7:0]      elem_q;
    logic [3:0][7:0] buf_q;
    logic [3:0][7:0] conv_buf;
    logic [2:0]      len_q;
    logic [2:0]      conv_len;
    logic [1:0]      idx_q;
    logic            req_ok;
    logic            last_char;
    logic            last_col;
    logic            last_row;
    logic            timer_exp;

    int8_to_ascii u_conv (
        .value    (elem_q),
        .char_buf (conv_buf),
        .char_len (conv_len)
    );

    assign req_ok = (fmt_m != 3'd0) && (fmt_m <= DIM_HI)
                 && (fmt_n != 3'd0) && (fmt_n <= DIM_HI)
                 && (fmt_id <= ID_HI);

    assign last_char = ({1'b0, idx_q} == len_q - 3'd1);
    assign last_col  = (col_q == n_q - 3'd1);
    assign last_row  = (row_q == m_q - 3'd1);
    assign timer_exp = (timer_q == TMO_LAST);
    assign disp_id   = id_q;

    always_comb begin
        state_d    = state_q;
        fmt_busy   = 1'b0;
        fmt_done   = 1'b0;
        fmt_err    = 1'b0;
        start_disp = 1'b0;
        read_en    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (fmt_start)
                    state_d = req_ok ? ST_START : ST_ABORT;
            end
            ST_START: begin
                fmt_busy   = 1'b1;
                start_disp = 1'b1;
                state_d    = ST_WAIT_META;
            end
            ST_WAIT_META: begin
                fmt_busy = 1'b1;
                if (error_flag)
                    state_d = ST_ABORT;
                else if (meta_info_valid)
                    state_d = ST_REQ;
                else if (timer_exp)
                    state_d = ST_ABORT;
            end
            ST_REQ: begin
                fmt_busy = 1'b1;
                read_en  = 1'b1;
                state_d  = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                fmt_busy = 1'b1;
                if (matrix_data_valid)
                    state_d = ST_CONV;
                else if (timer_exp)
                    state_d = ST_ABORT;
            end
            ST_CONV: begin
                fmt_busy = 1'b1;
                state_d  = ST_EMIT;
            end
            ST_EMIT: begin
                fmt_busy = 1'b1;
                tx_valid = 1'b1;
                tx_data  = buf_q[idx_q];
                if (tx_ready && last_char)
                    state_d = last_col ? ST_CR : ST_SEP;
            end
            ST_SEP: begin
                fmt_busy = 1'b1;
                tx_valid = 1'b1;
                tx_data  = SEP_CHAR;
                if (tx_ready)
                    state_d = ST_REQ;
            end
            ST_CR: begin
                fmt_busy = 1'b1;
                tx_valid = 1'b1;
                tx_data  = CHAR_CR;
                if (tx_ready)
                    state_d = ST_LF;
            end
            ST_LF: begin
                fmt_busy = 1'b1;
                tx_valid = 1'b1;
                tx_data  = CHAR_LF;
                if (tx_ready)
                    state_d = last_row ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                fmt_done = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_ABORT: begin
                fmt_err = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            m_q     <= '0;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            timer_q <= '0;
            elem_q  <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (fmt_start && req_ok) begin
                        id_q  <= fmt_id;
                        m_q   <= fmt_m;
                        n_q   <= fmt_n;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                // timer counts cycles elapsed since the start/read pulse
                ST_START, ST_REQ: timer_q <= TW'(1);
                ST_WAIT_META: timer_q <= timer_q + TW'(1);
                ST_WAIT_DATA: begin
                    timer_q <= timer_q + TW'(1);
                    if (matrix_data_valid)
                        elem_q <= st_data;
                end
                ST_CONV: begin
                    buf_q <= conv_buf;
                    len_q <= conv_len;
                    idx_q <= '0;
                end
                ST_EMIT: begin
                    if (tx_ready)
                        idx_q <= idx_q + 2'd1;
                end
                ST_SEP: begin
                    if (tx_ready)
                        col_q <= col_q + 3'd1;
                end
                ST_LF: begin
                    if (tx_ready) begin
                        col_q <= '0;
                        row_q <= row_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_display_formatter.sv
// Directed bench for matrix_display_formatter with a storage and UART sink model.
module tb_matrix_display_formatter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fmt_start = 1'b0;
    logic [3:0] fmt_id = '0;
    logic [2:0] fmt_m = '0;
    logic [2:0] fmt_n = '0;
    logic       fmt_busy;
    logic       fmt_done;
    logic       fmt_err;
    logic       start_disp;
    logic [3:0] disp_id;
    logic       read_en;
    logic       meta_info_valid = 1'b0;
    logic       error_flag = 1'b0;
    logic [7:0] st_data = '0;
    logic       matrix_data_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;

    always #5 clk = ~clk;

    matrix_display_formatter dut (
        .clk               (clk),
        .rst               (rst),
        .fmt_start         (fmt_start),
        .fmt_id            (fmt_id),
        .fmt_m             (fmt_m),
        .fmt_n             (fmt_n),
        .fmt_busy          (fmt_busy),
        .fmt_done          (fmt_done),
        .fmt_err           (fmt_err),
        .start_disp        (start_disp),
        .disp_id           (disp_id),
        .read_en           (read_en),
        .meta_info_valid   (meta_info_valid),
        .error_flag        (error_flag),
        .st_data           (st_data),
        .matrix_data_valid (matrix_data_valid),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] mem [0:31];
    int  rd_ptr = 0;
    int  answer_reads = -1;
    bit  err_mode = 1'b0;
    int  ready_mode = 0;
    int  stall_left = 0;
    bit  rd_seen = 1'b0;
    bit  meta_seen = 1'b0;

    byte unsigned rx_q[$];
    int  rd_cnt, sd_cnt, done_cnt, err_cnt;
    int  last_rd_cyc, err_cyc, stall_cnt, stall_bad;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // storage answers one cycle after a request; sink drives tx_ready
    always @(posedge clk) begin
        #1;
        matrix_data_valid = 1'b0;
        meta_info_valid   = 1'b0;
        error_flag        = 1'b0;
        if (rd_seen) begin
            if (answer_reads < 0 || rd_ptr < answer_reads) begin
                matrix_data_valid = 1'b1;
                st_data = mem[rd_ptr];
            end
            rd_ptr++;
        end
        if (meta_seen) begin
            if (err_mode) error_flag = 1'b1;
            else meta_info_valid = 1'b1;
        end
        rd_seen   = 1'b0;
        meta_seen = 1'b0;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin
                if (stall_left > 0) begin
                    tx_ready = 1'b0;
                    stall_left--;
                end else if ($urandom_range(0, 2) == 0) begin
                    tx_ready = 1'b0;
                    stall_left = 2;
                end else begin
                    tx_ready = 1'b1;
                end
            end
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (read_en) begin
            rd_seen = 1'b1;
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (start_disp) begin
            meta_seen = 1'b1;
            sd_cnt++;
        end
        if (fmt_done) done_cnt++;
        if (fmt_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_bad++;
        if (tx_valid && !tx_ready) stall_cnt++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_stream(input string tag, input string pat);
        byte unsigned exp_q[$];
        int bad_at = -1;
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "|") begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else begin
                exp_q.push_back(pat[i]);
            end
        end
        chk({tag, " len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (bad_at < 0 && rx_q[i] !== exp_q[i]) bad_at = i;
        chk({tag, " first bad byte idx"}, bad_at, -1);
    endtask

    task automatic clear_counts();
        rx_q.delete();
        rd_cnt = 0;
        sd_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
        last_rd_cyc = 0;
        err_cyc = 0;
        stall_cnt = 0;
        stall_bad = 0;
        rd_ptr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [3:0] id, input logic [2:0] m,
                           input logic [2:0] n);
        fmt_id = id;
        fmt_m = m;
        fmt_n = n;
        fmt_start = 1'b1;
        step();
        fmt_start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (fmt_done || fmt_err) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[3] = d;
    endtask

    bit ok;

    initial begin
        clear_counts();
        repeat (3) step();
        chk("reset flags",
            {26'd0, fmt_busy, fmt_done, fmt_err, start_disp, read_en, tx_valid}, 0);
        chk("reset disp_id", disp_id, 0);
        chk("reset tx_data", tx_data, 0);
        rst = 1'b0;
        step();

        // 2x2, no backpressure, plus an ignored request while busy
        clear_counts();
        load4(8'd1, 8'hF6, 8'd127, 8'd0);
        request(4'd3, 3'd2, 3'd2);
        chk("start_disp pulse", start_disp, 1);
        chk("disp_id latched", disp_id, 3);
        chk("busy after accept", fmt_busy, 1);
        repeat (5) step();
        request(4'd7, 3'd1, 3'd1);
        chk("disp_id held while busy", disp_id, 3);
        wait_end(400, ok);
        chk("2x2 finished in budget", ok, 1);
        step();
        chk_stream("2x2", "1 -10|127 0|");
        chk("2x2 read_en count", rd_cnt, 4);
        chk("2x2 start_disp count", sd_cnt, 1);
        chk("2x2 done count", done_cnt, 1);
        chk("2x2 err count", err_cnt, 0);
        chk("2x2 done is one cycle", fmt_done, 0);
        chk("2x2 busy low after", fmt_busy, 0);

        // element extremes
        clear_counts();
        mem[0] = 8'h80;
        mem[1] = 8'h00;
        mem[2] = 8'hFF;
        request(4'd0, 3'd1, 3'd3);
        wait_end(400, ok);
        chk("1x3 finished in budget", ok, 1);
        step();
        chk_stream("1x3", "-128 0 -1|");
        chk("1x3 read_en count", rd_cnt, 3);

        // backpressure: same stream, stable bytes while stalled
        clear_counts();
        load4(8'd1, 8'hF6, 8'd127, 8'd0);
        ready_mode = 1;
        request(4'd3, 3'd2, 3'd2);
        wait_end(3000, ok);
        chk("bp finished in budget", ok, 1);
        step();
        ready_mode = 0;
        chk_stream("bp", "1 -10|127 0|");
        chk("bp stalls seen", stall_cnt > 0, 1);
        chk("bp tx stable during stall", stall_bad, 0);
        chk("bp done count", done_cnt, 1);

        // storage error instead of meta_info_valid
        clear_counts();
        err_mode = 1'b1;
        request(4'd2, 3'd2, 3'd2);
        wait_end(200, ok);
        chk("st err ended in budget", ok, 1);
        step();
        err_mode = 1'b0;
        chk("st err err count", err_cnt, 1);
        chk("st err read_en count", rd_cnt, 0);
        chk("st err tx bytes", rx_q.size(), 0);
        chk("st err done count", done_cnt, 0);
        chk("st err pulse one cycle", fmt_err, 0);

        // rejected requests
        clear_counts();
        request(4'd1, 3'd6, 3'd2);
        chk("m=6 err next cycle", fmt_err, 1);
        chk("m=6 no start_disp", start_disp, 0);
        chk("m=6 not busy", fmt_busy, 0);
        step();
        chk("m=6 err one cycle", fmt_err, 0);
        request(4'd10, 3'd1, 3'd1);
        chk("id=10 err", fmt_err, 1);
        step();
        request(4'd1, 3'd2, 3'd0);
        chk("n=0 err", fmt_err, 1);
        step();
        chk("rejects issued no start_disp", sd_cnt, 0);
        chk("rejects err count", err_cnt, 3);

        // largest legal dimension and id
        clear_counts();
        load4(8'd5, 8'hFB, 8'd100, 8'h9C);
        mem[4] = 8'd99;
        request(4'd9, 3'd5, 3'd1);
        wait_end(600, ok);
        chk("5x1 finished in budget", ok, 1);
        step();
        chk_stream("5x1", "5|-5|100|-100|99|");
        chk("5x1 read_en count", rd_cnt, 5);

        // data withheld after the 2nd read_en
        clear_counts();
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        answer_reads = 1;
        request(4'd4, 3'd2, 3'd2);
        wait_end(400, ok);
        chk("tmo ended in budget", ok, 1);
        chk("tmo err raised", fmt_err, 1);
        chk("tmo busy fell", fmt_busy, 0);
        step();
        answer_reads = -1;
        chk("tmo read_en count", rd_cnt, 2);
        chk("tmo err delay", err_cyc - last_rd_cyc, 64);
        chk("tmo done count", done_cnt, 0);
        chk_stream("tmo", "1 ");

        // reset while stalled in EMIT, then a clean run
        clear_counts();
        mem[0] = 8'hFB;
        mem[1] = 8'd42;
        ready_mode = 2;
        request(4'd6, 3'd1, 3'd2);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("rst test reached EMIT", ok, 1);
        rst = 1'b1;
        step();
        chk("mid rst flags",
            {26'd0, fmt_busy, fmt_done, fmt_err, start_disp, read_en, tx_valid}, 0);
        chk("mid rst tx_data", tx_data, 0);
        chk("mid rst disp_id", disp_id, 0);
        rst = 1'b0;
        ready_mode = 0;
        repeat (3) step();
        chk("mid rst no done/err", done_cnt + err_cnt, 0);
        clear_counts();
        request(4'd6, 3'd1, 3'd2);
        wait_end(400, ok);
        chk("post rst finished in budget", ok, 1);
        step();
        chk_stream("post rst", "-5 42|");
        chk("post rst done count", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
